maxpool_ctrl: RTL

- Streaming 2x2 / stride-2 max-pool controller for the CNN accelerator's pooling stage.
- Accepts a raster-order feature map of signed Q8.8 pixels after the conv/ReLU stage and sequences the running-max compare across window columns and rows.
- Keeps one row of partial maxima in a line buffer and emits one pooled Q8.8 value per completed 2x2 window.
- Frames are launched by a start pulse and closed with a done pulse.

---
 rtl/pool_pkg.sv | 36 +++
 rtl/pool_linebuf.sv | 39 +++
 rtl/maxpool_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared definitions for the max-pool stage.
//               - Q8.8 pixel format constants
//               - FSM state encoding for maxpool_ctrl
//               - signed maximum helper (smax)
// Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

    // Q8.8 signed fixed point: 8 integer bits, 8 fraction bits.
    localparam int c_FRAC_BITS = 8;
    localparam int c_DATA_W    = 16;

    // Working width of smax. Callers sign-extend into it and truncate back,
    // so any pixel width up to this value shares the one helper.
    localparam int c_MAX_W     = 32;

    // Controller state encoding.
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Two's-complement maximum. On a tie both operands are the same value,
    // so which one is returned does not matter.
    function automatic logic signed [c_MAX_W-1:0] smax(
        input logic signed [c_MAX_W-1:0] a,
        input logic signed [c_MAX_W-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage : pool_pkg
`default_nettype wire

// File: rtl/pool_linebuf.sv
`default_nettype none
// ============================================================================
// Module      : pool_linebuf
// Description : Line buffer of partial row maxima for the 2x2 pooler.
//               DEPTH x N register array, one synchronous write port and one
//               combinational read port. Contents are not reset.
// Ports       : clk      - rising-edge clock
//               i_we     - write enable
//               i_waddr  - write index
//               i_wdata  - write data
//               i_raddr  - read index
//               o_rdata  - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module pool_linebuf #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  logic [N-1:0]  i_wdata,
    input  logic [IW-1:0] i_raddr,
    output logic [N-1:0]  o_rdata
);

    logic [N-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : pool_linebuf
`default_nettype wire

// File: rtl/maxpool_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_ctrl
// Description : Streaming 2x2 / stride-2 max-pool controller. Consumes a
//               raster-order frame of signed Q8.8 pixels and emits one pooled
//               maximum per completed 2x2 window. A frame is launched by a
//               start pulse and closed by a one-cycle done pulse.
// Ports       : clk        - rising-edge clock
//               reset      - asynchronous active-high reset
//               start      - frame launch pulse (honoured only when idle)
//               in_valid   - input pixel valid
//               in_ready   - controller can accept a pixel
//               din        - signed pixel, raster order
//               out_valid  - pooled value valid
//               out_ready  - consumer accepts the pooled value
//               dout       - pooled maximum
//               busy       - frame in progress (RUN or DRAIN)
//               done       - one-cycle pulse after last output is taken
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_ctrl
    import pool_pkg::*;
#(
    parameter int N     = c_DATA_W,   // pixel width, must not exceed c_MAX_W
    parameter int IMG_W = 8,          // even, >= 2
    parameter int IMG_H = 8           // even, >= 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] din,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] dout,
    output logic         busy,
    output logic         done
);

    localparam int c_CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_LB_DEPTH = IMG_W / 2;
    localparam int c_IW       = (c_LB_DEPTH > 1) ? $clog2(c_LB_DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_col;
    logic [c_RW-1:0] r_row;
    logic [N-1:0]    r_hold;
    logic [N-1:0]    r_dout;
    logic            r_out_valid;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic            w_in_ready;
    logic            w_accept;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_r0;
    logic            w_c0;
    logic            w_lb_we;
    logic            w_win_done;
    logic [c_IW-1:0] w_lb_idx;
    logic [N-1:0]    w_lb_rdata;
    logic [N-1:0]    w_max_hold;
    logic [N-1:0]    w_max_lb;

    // A new pixel is taken only if the output register is free or is being
    // drained this very cycle, so a completed window never overwrites an
    // unconsumed result.
    assign w_in_ready = (r_state == c_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;

    assign w_col_last = (r_col == c_CW'(IMG_W - 1));
    assign w_row_last = (r_row == c_RW'(IMG_H - 1));
    assign w_r0       = r_row[0];
    assign w_c0       = r_col[0];

    // Even row, odd column: pair max of the upper half of a window.
    assign w_lb_we    = w_accept && !w_r0 &&  w_c0;
    // Odd row, odd column: fourth pixel of a window.
    assign w_win_done = w_accept &&  w_r0 &&  w_c0;

    assign w_lb_idx   = c_IW'(r_col >> 1);

    assign w_max_hold = N'(smax(c_MAX_W'($signed(r_hold)),
                                c_MAX_W'($signed(din))));
    assign w_max_lb   = N'(smax(c_MAX_W'($signed(w_lb_rdata)),
                                c_MAX_W'($signed(din))));

    // ------------------------------------------------------------------
    // Line buffer of upper-row pair maxima
    // ------------------------------------------------------------------
    pool_linebuf #(
        .N     (N),
        .DEPTH (c_LB_DEPTH),
        .IW    (c_IW)
    ) u_linebuf (
        .clk     (clk),
        .i_we    (w_lb_we),
        .i_waddr (w_lb_idx),
        .i_wdata (w_max_hold),
        .i_raddr (w_lb_idx),
        .o_rdata (w_lb_rdata)
    );

    // ------------------------------------------------------------------
    // FSM and raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_RUN;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                c_RUN: begin
                    if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= w_row_last ? '0 : r_row + c_RW'(1);
                            if (w_row_last) begin
                                r_state <= c_DRAIN;
                            end
                        end else begin
                            r_col <= r_col + c_CW'(1);
                        end
                    end
                end
                c_DRAIN: begin
                    // The final window result was loaded on the last accept;
                    // leave once the consumer has taken it.
                    if (r_out_valid && out_ready) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hold and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= '0;
        end else if (w_accept && !w_c0) begin
            // Even column opens a pair: raw pixel on the upper row, or the
            // stored upper-pair max folded with it on the lower row.
            r_hold <= w_r0 ? w_max_lb : din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_win_done) begin
            // A completion in the same cycle as a handshake replaces the
            // consumed value with no bubble.
            r_dout      <= w_max_hold;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign busy      = (r_state == c_RUN) || (r_state == c_DRAIN);
    assign done      = (r_state == c_DONE);

endmodule : maxpool_ctrl
`default_nettype wire
